// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-address and read-data channels shared by the instruction and data
// refill paths; master is the arbiter, slave is the interconnect.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between the icache and
// dcache ports, with silent draining of a cancelled instruction burst.
module axi_rd_arbiter #(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter logic [3:0]  ID_INST = 4'd0,
  parameter logic [3:0]  ID_DATA = 4'd1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_rd_req,
  input  logic [ADDR_W-1:0] inst_rd_addr,
  input  logic [7:0]        inst_rd_len,
  input  logic [2:0]        inst_rd_size,
  output logic              inst_rd_rdy,
  input  logic              inst_cancel,
  output logic              inst_ret_valid,
  output logic              inst_ret_last,
  output logic [DATA_W-1:0] inst_ret_data,

  input  logic              data_rd_req,
  input  logic [ADDR_W-1:0] data_rd_addr,
  input  logic [7:0]        data_rd_len,
  input  logic [2:0]        data_rd_size,
  output logic              data_rd_rdy,
  output logic              data_ret_valid,
  output logic              data_ret_last,
  output logic [DATA_W-1:0] data_ret_data,

  axi_rd_arbiter_if.master  axi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_owner_q;
  logic              cancel_q;
  logic              arvalid_q;
  logic              rready_q;
  logic [3:0]        arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;

  logic inst_elig_s;
  logic grant_inst_s;
  logic grant_data_s;
  logic ar_hs_s;
  logic beat_s;
  logic inst_cancel_hit_s;
  logic unused_s;

  // A cancelled fetch is never eligible; on a tie the previous owner yields.
  assign inst_elig_s       = inst_rd_req && !inst_cancel;
  assign grant_inst_s      = inst_elig_s && (!data_rd_req || (last_owner_q == OWN_DATA));
  assign grant_data_s      = data_rd_req && !grant_inst_s;
  assign ar_hs_s           = arvalid_q && axi.arready;
  assign beat_s            = rready_q && axi.rvalid;
  assign inst_cancel_hit_s = inst_cancel && (owner_q == OWN_INST) && (state_q != S_IDLE);

  assign inst_rd_rdy    = ar_hs_s && (owner_q == OWN_INST) && !cancel_q && !inst_cancel;
  assign data_rd_rdy    = ar_hs_s && (owner_q == OWN_DATA);
  assign inst_ret_valid = beat_s && (owner_q == OWN_INST) && !cancel_q && !inst_cancel;
  assign inst_ret_last  = inst_ret_valid && axi.rlast;
  assign inst_ret_data  = axi.rdata;
  assign data_ret_valid = beat_s && (owner_q == OWN_DATA);
  assign data_ret_last  = data_ret_valid && axi.rlast;
  assign data_ret_data  = axi.rdata;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Owner comes from internal state, so the returned id and response are not used.
  assign unused_s = ^{axi.rid, axi.rresp};

  // Transaction FSM: grant in IDLE, hold AR until accepted, drain R until rlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_owner_q <= OWN_DATA;
      cancel_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      arid_q       <= 4'd0;
      araddr_q     <= {ADDR_W{1'b0}};
      arlen_q      <= 8'd0;
      arsize_q     <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cancel_q <= 1'b0;
          if (grant_inst_s) begin
            owner_q      <= OWN_INST;
            last_owner_q <= OWN_INST;
            arid_q       <= ID_INST;
            araddr_q     <= inst_rd_addr;
            arlen_q      <= inst_rd_len;
            arsize_q     <= inst_rd_size;
            arvalid_q    <= 1'b1;
            state_q      <= S_ADDR;
          end else if (grant_data_s) begin
            owner_q      <= OWN_DATA;
            last_owner_q <= OWN_DATA;
            arid_q       <= ID_DATA;
            araddr_q     <= data_rd_addr;
            arlen_q      <= data_rd_len;
            arsize_q     <= data_rd_size;
            arvalid_q    <= 1'b1;
            state_q      <= S_ADDR;
          end
        end
        S_ADDR: begin
          // The address phase must still complete after a cancel.
          if (inst_cancel_hit_s) begin
            cancel_q <= 1'b1;
          end
          if (ar_hs_s) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_s && axi.rlast) begin
            rready_q <= 1'b0;
            cancel_q <= 1'b0;
            state_q  <= S_IDLE;
          end else if (inst_cancel_hit_s) begin
            cancel_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          cancel_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
